sys_array_ws: RTL and testbench
===============================

Name: sys_array_ws

Overview:
- Parametrised weight-stationary N×N systolic matrix-multiply unit; next generation of the fixed 3×3 MMU.
- Adds an internal weight-load FSM, input skew and output deskew registers, a valid/ready handshake and a fixed pipeline latency.
- Sits between the activation buffer (data_in) and the accumulator/activation stage (acc_out).
- Each accepted input vector x yields exactly one output vector y, where y[j] = sum over i of x[i]*W[i][j].

Parameters:
- N, 3, array dimension (rows = cols = N); legal range 2..16.
- DATA_W, 8, signed width of each weight and data element.
- ACC_W, 24, signed width of each accumulator lane; must be ≥ 2*DATA_W + clog2(N).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high; clears all state.
- wt_load  in  1  one-cycle pulse in IDLE that starts a weight load.
- wt_valid  in  1  weight row beat valid.
- wt_in  in  N*DATA_W  one weight row; element j at [j*DATA_W +: DATA_W].
- data_valid  in  1  input vector valid.
- data_last  in  1  marks the final vector of a batch; qualified by data_valid.
- data_in  in  N*DATA_W  input vector; element i at [i*DATA_W +: DATA_W].
- data_ready  out  1  high only in COMPUTE.
- out_valid  out  1  acc_out holds one complete result vector.
- acc_out  out  N*ACC_W  result vector; lane j at [j*ACC_W +: ACC_W].
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (synchronous, active-high): FSM → IDLE; all weight registers, skew/deskew registers and PE partial sums → 0; data_ready=0, out_valid=0, acc_out=0, busy=0.
- FSM states: IDLE, LOAD_WT, COMPUTE, DRAIN.
- IDLE: wt_load=1 → LOAD_WT; row counter ← 0.
- LOAD_WT: each cycle with wt_valid=1 writes wt_in to weight row[cnt] and increments cnt. When the beat for row N-1 is written → COMPUTE. Cycles with wt_valid=0 stall the load and are not an error.
- COMPUTE: data_ready=1. A vector is accepted on data_valid & data_ready. Accepting a vector with data_last=1 → DRAIN. Vectors may arrive on consecutive cycles, giving full throughput of one vector per cycle. Gaps with data_valid=0 inject bubbles, which produce no out_valid.
- DRAIN: data_ready=0. Lasts exactly 2N cycles after acceptance of the last vector, then → IDLE. Weights are retained, so a new batch needs a reload via wt_load.
- Latency: the vector accepted at cycle t produces out_valid=1 with its acc_out at cycle t+2N (6 for N=3). out_valid order equals acceptance order; there is no backpressure on the output.
- Skew: row i of the input is delayed i cycles. Deskew: column j of the output is delayed N-1-j cycles, so all lanes align.
- A valid bit travels with each vector through the skew and array pipeline.
- Arithmetic: signed DATA_W × DATA_W product, sign-extended to ACC_W, accumulated down each column. The sum wraps modulo 2^ACC_W; there is no saturation.
- acc_out holds its last value when out_valid=0.
- wt_load outside IDLE is ignored.
- wt_valid outside LOAD_WT is ignored.
- data_valid outside COMPUTE is ignored, and those vectors are dropped.
- data_valid and data_last in the same cycle as the final weight beat: the vector is ignored, because data_ready is still 0.
- Reset mid-LOAD_WT, mid-COMPUTE or mid-DRAIN: any in-flight vectors are discarded and no out_valid occurs afterwards.

Decomposition:
- Package sys_array_pkg holds:
  - state enum (IDLE, LOAD_WT, COMPUTE, DRAIN);
  - default DATA_W and ACC_W localparams;
  - function lat(N) = 2*N.
- Sub-module sys_pe: one processing element containing the stationary weight register, the data pass-through register and the psum register (psum_out = psum_in + a*w). It has a weight-load enable.
- The top level generates the N×N sys_pe grid plus the skew/deskew shift registers and the FSM.

Test Plan:
- Identity load: N=3, W=I, then x=(5,-7,9) with data_last=1 → one out_valid exactly 6 cycles after acceptance, acc_out lanes=(5,-7,9). FSM returns to IDLE after DRAIN.
- General weights: W rows (2,3,4),(1,2,3),(4,1,2).
  - x=(1,2,0) → y=(4,7,10).
  - x=(1,1,1) → y=(7,6,9).
  - x=(-1,0,0) → y=(-2,-3,-4).
- Streaming: four vectors accepted on consecutive cycles → out_valid high for four consecutive cycles starting at t0+6, results in order.
- Bubbles and stall:
  - wt_valid deasserted for 2 cycles mid-load → load completes correctly.
  - data_valid gaps → the out_valid pattern mirrors the input pattern shifted by 6 cycles.
- Extremes: DATA_W=8, W all -128, x all -128 → each lane = 3*16384 = 49152, which fits in ACC_W=24 with no wrap.
- Reset mid-COMPUTE: two vectors in flight, then reset for 1 cycle → no out_valid afterwards; busy=0, acc_out=0; weights zero, so y=(0,0,0) until reload.

Source files
------------

// File: rtl/sys_array_pkg.sv
// sys_array_pkg: shared FSM state type, default widths and pipeline latency helper
package sys_array_pkg;

    typedef enum logic [1:0] {IDLE, LOAD_WT, COMPUTE, DRAIN} state_t;

    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 24;

    function automatic int lat(input int n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/sys_pe.sv
// sys_pe: one weight-stationary processing element (held weight, data pass-through, psum stage)
module sys_pe #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     w_en,
    input  logic signed [DATA_W-1:0] w_in,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic        [ACC_W-1:0]  psum_in,
    output logic signed [DATA_W-1:0] a_out,
    output logic        [ACC_W-1:0]  psum_out
);

    logic signed [DATA_W-1:0]   w;
    logic signed [2*DATA_W-1:0] prod;

    assign prod = (2*DATA_W)'(a_in) * (2*DATA_W)'(w);

    // weight holds until the next load; data moves right and the partial sum moves down every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            w        <= '0;
            a_out    <= '0;
            psum_out <= '0;
        end else begin
            if (w_en) w <= w_in;
            a_out    <= a_in;
            psum_out <= psum_in + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/sys_array_ws.sv
// sys_array_ws: parametrised N x N weight-stationary systolic matrix-vector unit with skew/deskew and load FSM
module sys_array_ws
    import sys_array_pkg::*;
#(
    parameter int N      = 3,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wt_load,
    input  logic                  wt_valid,
    input  logic [N*DATA_W-1:0]   wt_in,
    input  logic                  data_valid,
    input  logic                  data_last,
    input  logic [N*DATA_W-1:0]   data_in,
    output logic                  data_ready,
    output logic                  out_valid,
    output logic [N*ACC_W-1:0]    acc_out,
    output logic                  busy
);

    localparam int L  = lat(N);
    localparam int CW = $clog2(L) + 1;

    state_t                   state, state_nx;
    logic [CW-1:0]            cnt;
    logic                     load_beat;
    logic                     accept;
    logic [N-1:0]             we;
    logic [L-1:0]             vld;
    logic signed [DATA_W-1:0] feed [N];
    logic signed [DATA_W-1:0] a_h  [N][N-1];
    logic [ACC_W-1:0]         p_v  [N][N];
    logic [ACC_W-1:0]         col  [N];

    assign load_beat = (state == LOAD_WT) && wt_valid;
    assign accept    = data_valid && data_ready;
    assign out_valid = vld[L-1];

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (wt_load) state_nx = LOAD_WT;
            LOAD_WT: if (load_beat && cnt == CW'(N-1)) state_nx = COMPUTE;
            COMPUTE: if (accept && data_last) state_nx = DRAIN;
            DRAIN:   if (cnt == CW'(L-1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        data_ready = (state == COMPUTE);
        busy       = (state != IDLE);
    end

    // row index during load, cycle count during drain; restarts on every state change
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else       cnt <= (state_nx != state) ? '0 : cnt + CW'(state != LOAD_WT || wt_valid);
    end

    // one-hot row write enable for the weight beat currently being loaded
    always_comb begin
        for (int i = 0; i < N; i++) we[i] = load_beat && (cnt == CW'(i));
    end

    // valid bit shadows each accepted vector through skew, array and deskew
    always_ff @(posedge clk) begin
        if (reset) vld <= '0;
        else       vld <= {vld[L-2:0], accept};
    end

    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign feed[i] = data_in[0 +: DATA_W];
        end else begin : g_delay
            logic [DATA_W-1:0] s [i];
            // row i enters i cycles late to meet the partial sum coming down its column
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < i; k++) s[k] <= '0;
                end else begin
                    s[0] <= data_in[i*DATA_W +: DATA_W];
                    for (int k = 1; k < i; k++) s[k] <= s[k-1];
                end
            end
            assign feed[i] = s[i-1];
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic signed [DATA_W-1:0] a_i, a_o;
            logic [ACC_W-1:0]         p_i;
            if (j == 0) begin : g_first
                assign a_i = feed[i];
            end else begin : g_inner
                assign a_i = a_h[i][j-1];
            end
            if (j < N-1) begin : g_pass
                assign a_h[i][j] = a_o;
            end else begin : g_tail
                logic signed [DATA_W-1:0] a_unused;
                assign a_unused = a_o;
            end
            if (i == 0) begin : g_top
                assign p_i = '0;
            end else begin : g_below
                assign p_i = p_v[i-1][j];
            end
            sys_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
                .clk      (clk),
                .reset    (reset),
                .w_en     (we[i]),
                .w_in     (wt_in[j*DATA_W +: DATA_W]),
                .a_in     (a_i),
                .psum_in  (p_i),
                .a_out    (a_o),
                .psum_out (p_v[i][j])
            );
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_deskew
        if (j == N-1) begin : g_direct
            assign col[j] = p_v[N-1][j];
        end else begin : g_delay
            logic [ACC_W-1:0] d [N-1-j];
            // column j finishes N-1-j cycles before the last column, so hold it back to align lanes
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int k = 0; k < N-1-j; k++) d[k] <= '0;
                end else begin
                    d[0] <= p_v[N-1][j];
                    for (int k = 1; k < N-1-j; k++) d[k] <= d[k-1];
                end
            end
            assign col[j] = d[N-2-j];
        end
    end

    // capture the aligned result row; hold it between valid results
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_out <= '0;
        end else if (vld[L-2]) begin
            for (int j = 0; j < N; j++) acc_out[j*ACC_W +: ACC_W] <= col[j];
        end
    end

endmodule

// File: tb/tb_sys_array_ws.sv
// tb_sys_array_ws: directed self-checking bench for the 3x3 weight-stationary array
module tb_sys_array_ws;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int AW = 24;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            wt_load = 1'b0;
    logic            wt_valid = 1'b0;
    logic            data_valid = 1'b0;
    logic            data_last = 1'b0;
    logic [N*DW-1:0] wt_in = '0;
    logic [N*DW-1:0] data_in = '0;
    logic            data_ready, out_valid, busy;
    logic [N*AW-1:0] acc_out;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    sys_array_ws #(.N(N), .DATA_W(DW), .ACC_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .wt_load    (wt_load),
        .wt_valid   (wt_valid),
        .wt_in      (wt_in),
        .data_valid (data_valid),
        .data_last  (data_last),
        .data_in    (data_in),
        .data_ready (data_ready),
        .out_valid  (out_valid),
        .acc_out    (acc_out),
        .busy       (busy)
    );

    function automatic logic [N*DW-1:0] v3(input int a, input int b, input int c);
        logic [N*DW-1:0] r;
        r = {DW'(c), DW'(b), DW'(a)};
        return r;
    endfunction

    function automatic logic [N*AW-1:0] y3(input int a, input int b, input int c);
        logic [N*AW-1:0] r;
        r = {AW'(c), AW'(b), AW'(a)};
        return r;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [N*DW-1:0] r0, input logic [N*DW-1:0] r1,
                        input logic [N*DW-1:0] r2, input int stall_at, input bit dv_on_last);
        logic [N*DW-1:0] rows [N];
        rows[0] = r0;
        rows[1] = r1;
        rows[2] = r2;
        wt_load = 1'b1;
        step(1);
        wt_load = 1'b0;
        for (int r = 0; r < N; r++) begin
            if (r == stall_at) begin
                wt_valid = 1'b0;
                wt_in = v3(99, 99, 99);
                step(2);
            end
            wt_valid = 1'b1;
            wt_in = rows[r];
            if (r == N-1 && dv_on_last) begin
                data_valid = 1'b1;
                data_last = 1'b1;
                data_in = v3(9, 9, 9);
            end
            step(1);
        end
        wt_valid = 1'b0;
        data_valid = 1'b0;
        data_last = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        checks++; if (data_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", data_ready); else passed++;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
        checks++; if (acc_out !== '0) $display("FAIL reset_acc got %h want 0", acc_out); else passed++;
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_identity();
        load(v3(1, 0, 0), v3(0, 1, 0), v3(0, 0, 1), -1, 1'b0);
        checks++; if (data_ready !== 1'b1) $display("FAIL ident_ready got %b want 1", data_ready); else passed++;
        data_valid = 1'b1;
        data_last = 1'b1;
        data_in = v3(5, -7, 9);
        step(1);
        checks++; if (data_ready !== 1'b0 || busy !== 1'b1) $display("FAIL ident_drain_flags got ready=%b busy=%b want 0 1", data_ready, busy); else passed++;
        data_in = v3(1, 1, 1);
        wt_load = 1'b1;
        step(1);
        data_valid = 1'b0;
        data_last = 1'b0;
        wt_load = 1'b0;
        step(3);
        checks++; if (out_valid !== 1'b0) $display("FAIL ident_early got %b want 0", out_valid); else passed++;
        step(1);
        checks++; if (out_valid !== 1'b1) $display("FAIL ident_latency got %b want 1", out_valid); else passed++;
        checks++; if (acc_out !== y3(5, -7, 9)) $display("FAIL ident_acc got %h want %h", acc_out, y3(5, -7, 9)); else passed++;
        checks++; if (busy !== 1'b1) $display("FAIL ident_busy_drain got %b want 1", busy); else passed++;
        step(1);
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) $display("FAIL ident_idle got busy=%b ov=%b want 0 0", busy, out_valid); else passed++;
        checks++; if (acc_out !== y3(5, -7, 9)) $display("FAIL ident_hold got %h want %h", acc_out, y3(5, -7, 9)); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [N*DW-1:0] xs [4];
        logic [N*AW-1:0] ys [4];
        xs[0] = v3(1, 2, 0);  ys[0] = y3(4, 7, 10);
        xs[1] = v3(1, 1, 1);  ys[1] = y3(7, 6, 9);
        xs[2] = v3(-1, 0, 0); ys[2] = y3(-2, -3, -4);
        xs[3] = v3(3, -2, 5); ys[3] = y3(24, 10, 16);
        load(v3(2, 3, 4), v3(1, 2, 3), v3(4, 1, 2), 1, 1'b0);
        checks++; if (data_ready !== 1'b1) $display("FAIL b2b_stalled_load got ready=%b want 1", data_ready); else passed++;
        for (int k = 0; k < 4; k++) begin
            data_valid = 1'b1;
            data_last = (k == 3);
            data_in = xs[k];
            step(1);
        end
        data_valid = 1'b0;
        data_last = 1'b0;
        step(1);
        for (int c = 5; c <= 10; c++) begin
            bit ev;
            ev = (c >= 6 && c <= 9);
            checks++; if (out_valid !== ev) $display("FAIL b2b_valid c=%0d got %b want %b", c, out_valid, ev); else passed++;
            if (ev) begin
                checks++; if (acc_out !== ys[c-6]) $display("FAIL b2b_acc c=%0d got %h want %h", c, acc_out, ys[c-6]); else passed++;
            end
            step(1);
        end
    endtask

    task automatic test_bubbles();
        logic [13:0]     pat;
        logic [N*DW-1:0] xs [14];
        logic [N*AW-1:0] ys [14];
        pat = 14'b00000001001011;
        for (int k = 0; k < 14; k++) begin
            xs[k] = '0;
            ys[k] = '0;
        end
        xs[0] = v3(1, 2, 0);  ys[0] = y3(4, 7, 10);
        xs[1] = v3(1, 1, 1);  ys[1] = y3(7, 6, 9);
        xs[3] = v3(-1, 0, 0); ys[3] = y3(-2, -3, -4);
        xs[6] = v3(3, -2, 5); ys[6] = y3(24, 10, 16);
        load(v3(2, 3, 4), v3(1, 2, 3), v3(4, 1, 2), -1, 1'b1);
        checks++; if (data_ready !== 1'b1) $display("FAIL bub_last_beat_drop got ready=%b want 1", data_ready); else passed++;
        for (int c = 0; c < 14; c++) begin
            bit ev;
            ev = (c >= 6) ? pat[c-6] : 1'b0;
            data_valid = pat[c];
            data_last = (c == 6);
            data_in = xs[c];
            checks++; if (out_valid !== ev) $display("FAIL bub_valid c=%0d got %b want %b", c, out_valid, ev); else passed++;
            if (ev) begin
                checks++; if (acc_out !== ys[c-6]) $display("FAIL bub_acc c=%0d got %h want %h", c, acc_out, ys[c-6]); else passed++;
            end
            step(1);
        end
        data_valid = 1'b0;
        data_last = 1'b0;
        checks++; if (busy !== 1'b0) $display("FAIL bub_idle got %b want 0", busy); else passed++;
    endtask

    task automatic test_extremes();
        load(v3(-128, -128, -128), v3(-128, -128, -128), v3(-128, -128, -128), -1, 1'b0);
        data_valid = 1'b1;
        data_last = 1'b1;
        data_in = v3(-128, -128, -128);
        step(1);
        data_valid = 1'b0;
        data_last = 1'b0;
        step(5);
        checks++; if (out_valid !== 1'b1) $display("FAIL ext_valid got %b want 1", out_valid); else passed++;
        checks++; if (acc_out !== y3(49152, 49152, 49152)) $display("FAIL ext_acc got %h want %h", acc_out, y3(49152, 49152, 49152)); else passed++;
        step(2);
    endtask

    task automatic test_reset_mid();
        int seen;
        load(v3(2, 3, 4), v3(1, 2, 3), v3(4, 1, 2), -1, 1'b0);
        data_valid = 1'b1;
        data_in = v3(1, 2, 0);
        step(1);
        data_in = v3(1, 1, 1);
        step(1);
        data_valid = 1'b0;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (out_valid) seen++;
            step(1);
        end
        checks++; if (seen !== 0) $display("FAIL rmid_out_valid got %0d pulses want 0", seen); else passed++;
        checks++; if (busy !== 1'b0) $display("FAIL rmid_busy got %b want 0", busy); else passed++;
        checks++; if (data_ready !== 1'b0) $display("FAIL rmid_ready got %b want 0", data_ready); else passed++;
        checks++; if (acc_out !== '0) $display("FAIL rmid_acc got %h want 0", acc_out); else passed++;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_back_to_back();
        test_bubbles();
        test_extremes();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
